// File: rtl/branch_target_buffer_pkg.sv
// Shared constants and helpers for the branch target buffer.
// Counter encodings and index-width math live here.
package btb_pkg;

  localparam int CTR_SNT = 0;

  function automatic int ctr_weak_taken(input int bits);
    return 1 << (bits - 1);
  endfunction

  function automatic int ctr_weak_nt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int btb_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup, MEM-stage update and debug statistics bundle
// between the pipeline (master) and the BTB (slave).
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic [ADDR_W-1:0] IF_PC;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              inv_all;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output IF_PC, upd_valid, upd_pc, upd_taken,
    output upd_target, upd_mispredict, inv_all,
    input  pred_hit, pred_taken, pred_next_pc,
    input  stat_updates, stat_mispredicts
  );

  modport slave (
    input  IF_PC, upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_mispredict, inv_all,
    output pred_hit, pred_taken, pred_next_pc,
    output stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter.sv
// Up/down counter that saturates at zero and all-ones,
// with a parallel load that takes priority over counting.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= RST_VAL;
    else if (load)
      value <= load_val;
    else if (inc && !dec && value != '1)
      value <= value + 1'b1;
    else if (dec && !inc && value != '0)
      value <= value - 1'b1;
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational fetch lookup, MEM-stage
// update/allocate, per-entry direction counters, saturating stats.
module branch_target_buffer #(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  branch_target_buffer_if.slave bus
);
  import btb_pkg::*;

  localparam int IDX_W = btb_log2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] WT =
    CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WNT =
    CTR_BITS'(ctr_weak_nt(CTR_BITS));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } entry_t;

  entry_t              tbl [ENTRIES];
  logic [CTR_BITS-1:0] ctr [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  entry_t           lk_e, up_e;
  logic             up_hit, upd_en;
  logic             do_step, do_alloc;
  logic             unused_lo;

  assign lk_idx = bus.IF_PC[IDX_W+1:2];
  assign lk_tag = bus.IF_PC[ADDR_W-1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_lo = ^bus.upd_pc[1:0];

  assign lk_e = tbl[lk_idx];
  assign up_e = tbl[up_idx];

  assign bus.pred_hit =
    lk_e.valid && (lk_e.tag == lk_tag);
  assign bus.pred_taken =
    bus.pred_hit && ctr[lk_idx][CTR_BITS-1];
  assign bus.pred_next_pc = bus.pred_taken ?
    lk_e.target : bus.IF_PC + ADDR_W'(4);

  // inv_all suppresses the whole entry update, not just valid
  assign up_hit   = up_e.valid && (up_e.tag == up_tag);
  assign upd_en   = bus.upd_valid && !bus.inv_all;
  assign do_step  = upd_en && up_hit;
  assign do_alloc = upd_en && !up_hit && bus.upd_taken;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '0;
    end else if (bus.inv_all) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i].valid <= 1'b0;
    end else if (do_alloc) begin
      tbl[up_idx] <= '{valid:  1'b1,
                       tag:    up_tag,
                       target: bus.upd_target};
    end else if (do_step && bus.upd_taken) begin
      tbl[up_idx].target <= bus.upd_target;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = (up_idx == IDX_W'(g));
    sat_counter #(
      .W       (CTR_BITS),
      .RST_VAL (WNT)
    ) u_ctr (
      .clk      (Clk),
      .rst      (Reset),
      .inc      (do_step && sel && bus.upd_taken),
      .dec      (do_step && sel && !bus.upd_taken),
      .load     (do_alloc && sel),
      .load_val (WT),
      .value    (ctr[g])
    );
  end

  sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_stat_upd (
    .clk      (Clk),
    .rst      (Reset),
    .inc      (bus.upd_valid),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .value    (bus.stat_updates)
  );

  sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_stat_mis (
    .clk      (Clk),
    .rst      (Reset),
    .inc      (bus.upd_valid && bus.upd_mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .value    (bus.stat_mispredicts)
  );

endmodule
